// File: rtl/palindrome_pkg.sv
// Shared constants and types for the serial palindrome detector.
package palindrome_pkg;

  localparam int WIN_LEN = 3;
  localparam int FILL_W  = 2;

  typedef enum logic [FILL_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } fill_e;

  // True when the window reads the same from both ends.
  // The middle bit of an odd-length window always compares with itself.
  function automatic logic is_palindrome(input logic [WIN_LEN-1:0] w);
    logic same;
    same = 1'b1;
    for (int i = 0; i < WIN_LEN; i++) begin
      if (w[i] != w[WIN_LEN-1-i]) same = 1'b0;
    end
    return same;
  endfunction

endpackage

// File: rtl/palindrome_3b_bit_window.sv
// Serial shift window with a saturating fill tracker.
// window[0] holds the newest bit; full rises once WIN_LEN bits are captured.
module bit_window
  import palindrome_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  output logic [WIN_LEN-1:0] window,
  output logic               full
);

  fill_e fill;
  fill_e fill_next;

  // Fill state register.
  always_ff @(posedge clk) begin
    if (reset) fill <= EMPTY;
    else       fill <= fill_next;
  end

  // Fill progression: one step per captured bit, holding at FULL.
  always_comb begin
    fill_next = fill;
    case (fill)
      EMPTY:   fill_next = ONE;
      ONE:     fill_next = TWO;
      TWO:     fill_next = FULL;
      FULL:    fill_next = FULL;
      default: fill_next = EMPTY;
    endcase
  end

  // Shift the new bit in at the low end; reset clears stale history.
  always_ff @(posedge clk) begin
    if (reset) window <= '0;
    else       window <= {window[WIN_LEN-2:0], din};
  end

  assign full = (fill == FULL);

endmodule

// File: rtl/palindrome_3b.sv
// Serial 3-bit palindrome detector: flags when the newest captured bit
// matches the one captured two edges earlier. Output decodes registers only.
module palindrome_3b
  import palindrome_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x_i,
  output logic palindrome_o
);

  logic [WIN_LEN-1:0] window;
  logic               full;

  bit_window u_window (
    .clk    (clk),
    .reset  (reset),
    .din    (x_i),
    .window (window),
    .full   (full)
  );

  // A verdict is only meaningful once the window holds three real bits.
  assign palindrome_o = full && is_palindrome(window);

endmodule

// File: tb/tb_palindrome_3b.sv
// Self-checking bench for palindrome_3b: directed test-plan steps plus a
// random stream, compared against a queue-based history model.
module tb_palindrome_3b;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic x_i = 1'b0;
  logic palindrome_o;

  int checks = 0;
  int errors = 0;
  bit hist[$];

  palindrome_3b dut (
    .clk          (clk),
    .reset        (reset),
    .x_i          (x_i),
    .palindrome_o (palindrome_o)
  );

  always #5 clk = ~clk;

  function automatic bit model_out();
    if (hist.size() < 3) return 1'b0;
    return hist[0] == hist[2];
  endfunction

  // One clock edge: drive at negedge, sample 1ns after posedge, compare
  // against the model and, when exp >= 0, against a directed constant.
  task automatic step(input bit r, input bit x, input int exp, input string tag);
    bit m;
    @(negedge clk);
    reset = r;
    x_i   = x;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
    end else begin
      hist.push_back(x);
      if (hist.size() > 3) void'(hist.pop_front());
    end
    m = model_out();
    checks++;
    assert (palindrome_o === m)
      else begin
        errors++;
        $error("FAIL %s model observed=%0b expected=%0b", tag, palindrome_o, m);
      end
    if (exp >= 0) begin
      checks++;
      assert (palindrome_o === exp[0])
        else begin
          errors++;
          $error("FAIL %s directed observed=%0b expected=%0b", tag, palindrome_o, exp[0]);
        end
    end
  endtask

  initial begin
    bit seq_a[8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    bit exp_a[8] = '{0, 0, 1, 0, 1, 1, 0, 1};

    // Reset held for two edges, then three zeros.
    step(1, 0, 0, "reset0");
    step(1, 1, 0, "reset1");
    step(0, 0, 0, "zeros_e1");
    step(0, 0, 0, "zeros_e2");
    step(0, 0, 1, "zeros_e3");

    // Mixed stream from reset.
    step(1, 0, 0, "seqa_rst");
    for (int i = 0; i < 8; i++) step(0, seq_a[i], exp_a[i], $sformatf("seqa_%0d", i));

    // Two ones, then x_i wiggles without an edge: output must not move.
    step(1, 0, 0, "hold_rst");
    step(0, 1, 0, "hold_e1");
    step(0, 1, 0, "hold_e2");
    @(negedge clk);
    x_i = 1'b0;
    #2;
    x_i = 1'b1;
    #1;
    checks++;
    assert (palindrome_o === 1'b0)
      else begin
        errors++;
        $error("FAIL hold_noedge observed=%0b expected=0", palindrome_o);
      end
    step(0, 1, 1, "hold_e3");

    // 1,1,0 -> 101 -> 011, then 111 and a mid-stream reset with x_i=1.
    step(1, 0, 0, "s110_rst");
    step(0, 1, 0, "s110_e1");
    step(0, 1, 0, "s110_e2");
    step(0, 0, 0, "s110_e3");
    step(0, 1, 1, "s101");
    step(0, 1, 0, "s011");
    step(0, 1, 1, "s111");
    step(1, 1, 0, "midrst");
    step(0, 1, 0, "after_e1");
    step(0, 1, 0, "after_e2");
    step(0, 1, 1, "after_e3");

    // Random stream with occasional reset pulses.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), -1, $sformatf("rand_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
